// File: rtl/sobel_window_gen_pkg.sv
// Shared constants for the 3x3 Sobel window generator: pixel width, default
// image size and the slot order of the window register array.
package sobel_window_gen_pkg;

  localparam int PIX_W     = 8;
  localparam int IMG_W_DEF = 512;
  localparam int IMG_H_DEF = 512;

  // Window slots: the first eight match the win0..win7 port order, and the centre is last.
  localparam int WIN_TL = 0;
  localparam int WIN_TC = 1;
  localparam int WIN_TR = 2;
  localparam int WIN_ML = 3;
  localparam int WIN_MR = 4;
  localparam int WIN_BL = 5;
  localparam int WIN_BC = 6;
  localparam int WIN_BR = 7;
  localparam int WIN_C  = 8;
  localparam int WIN_N  = 9;

endpackage

// File: rtl/sobel_line_buf.sv
// One-line pixel store: one write port and one registered read port.
// When both ports hit the same address, the read returns the old data.
module sobel_line_buf
  import sobel_window_gen_pkg::*;
#(
  parameter int DEPTH = IMG_W_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [PIX_W-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [PIX_W-1:0] rdata
);

  logic [PIX_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    rdata <= mem[raddr];
    if (we) mem[waddr] <= wdata;
  end

endmodule

// File: rtl/sobel_window_gen.sv
// Builds 3x3 neighbourhood windows from a raster pixel stream using two line
// buffers. It emits one window per interior pixel, with backpressure from win_ready.
module sobel_window_gen
  import sobel_window_gen_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [PIX_W-1:0]         pix_in,
  input  logic                     pix_sof,
  input  logic                     pix_valid,
  output logic                     pix_ready,
  output logic [PIX_W-1:0]         win0,
  output logic [PIX_W-1:0]         win1,
  output logic [PIX_W-1:0]         win2,
  output logic [PIX_W-1:0]         win3,
  output logic [PIX_W-1:0]         win4,
  output logic [PIX_W-1:0]         win5,
  output logic [PIX_W-1:0]         win6,
  output logic [PIX_W-1:0]         win7,
  output logic [PIX_W-1:0]         win_c,
  output logic [$clog2(IMG_H)-1:0] win_row,
  output logic [$clog2(IMG_W)-1:0] win_col,
  output logic                     win_valid,
  input  logic                     win_ready,
  output logic                     frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST     = CW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_WIN_LAST = CW'(IMG_W - 2);
  localparam logic [CW-1:0] COL_FIRST_W  = CW'(2);
  localparam logic [RW-1:0] ROW_LAST     = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_WIN_LAST = RW'(IMG_H - 2);
  localparam logic [RW-1:0] ROW_FIRST_W  = RW'(2);

  logic [CW-1:0]    col_cnt, col_nxt, cur_col;
  logic [RW-1:0]    row_cnt, row_nxt, cur_row;
  logic             accept, win_done;
  logic [PIX_W-1:0] lb1_rd, lb2_rd;
  logic [PIX_W-1:0] win_r [WIN_N];

  assign pix_ready = win_ready | ~win_valid;
  assign accept    = pix_valid & pix_ready;

  always_comb begin
    cur_col  = pix_sof ? '0 : col_cnt;
    cur_row  = pix_sof ? '0 : row_cnt;
    col_nxt  = col_cnt;
    row_nxt  = row_cnt;
    win_done = 1'b0;
    if (accept) begin
      win_done = (cur_row >= ROW_FIRST_W) && (cur_col >= COL_FIRST_W);
      if (cur_col == COL_LAST) begin
        col_nxt = '0;
        row_nxt = (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
      end else begin
        col_nxt = cur_col + CW'(1);
        row_nxt = cur_row;
      end
    end
  end

  // Read addresses follow the column of the next pixel, so the registered
  // read data is ready when that pixel arrives. An sof pixel gets stale
  // reads, but those land only in row-0 windows, which are never emitted.
  sobel_line_buf #(.DEPTH(IMG_W), .AW(CW)) u_lb1 (
    .clk   (clk),
    .we    (accept),
    .waddr (cur_col),
    .wdata (pix_in),
    .raddr (col_nxt),
    .rdata (lb1_rd)
  );

  sobel_line_buf #(.DEPTH(IMG_W), .AW(CW)) u_lb2 (
    .clk   (clk),
    .we    (accept),
    .waddr (cur_col),
    .wdata (lb1_rd),
    .raddr (col_nxt),
    .rdata (lb2_rd)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col_cnt    <= '0;
      row_cnt    <= '0;
      win_valid  <= 1'b0;
      win_row    <= '0;
      win_col    <= '0;
      frame_done <= 1'b0;
      for (int i = 0; i < WIN_N; i++) win_r[i] <= '0;
    end else begin
      col_cnt    <= col_nxt;
      row_cnt    <= row_nxt;
      frame_done <= win_valid & win_ready &
                    (win_row == ROW_WIN_LAST) & (win_col == COL_WIN_LAST);
      if (accept) begin
        win_r[WIN_TL] <= win_r[WIN_TC];
        win_r[WIN_TC] <= win_r[WIN_TR];
        win_r[WIN_TR] <= lb2_rd;
        win_r[WIN_ML] <= win_r[WIN_C];
        win_r[WIN_C]  <= win_r[WIN_MR];
        win_r[WIN_MR] <= lb1_rd;
        win_r[WIN_BL] <= win_r[WIN_BC];
        win_r[WIN_BC] <= win_r[WIN_BR];
        win_r[WIN_BR] <= pix_in;
        win_valid     <= win_done;
        if (win_done) begin
          win_row <= cur_row - RW'(1);
          win_col <= cur_col - CW'(1);
        end
      end else if (win_ready) begin
        win_valid <= 1'b0;
      end
    end
  end

  assign win0  = win_r[WIN_TL];
  assign win1  = win_r[WIN_TC];
  assign win2  = win_r[WIN_TR];
  assign win3  = win_r[WIN_ML];
  assign win4  = win_r[WIN_MR];
  assign win5  = win_r[WIN_BL];
  assign win6  = win_r[WIN_BC];
  assign win7  = win_r[WIN_BR];
  assign win_c = win_r[WIN_C];

endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed bench for sobel_window_gen on an 8x6 image with pixel = row*16+col.
// Captured windows are compared against a table of expected windows.
module tb_sobel_window_gen;

  localparam int W = 8;
  localparam int H = 6;
  localparam int NWIN = (W - 2) * (H - 2);

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] pix_in = '0;
  logic       pix_sof = 1'b0;
  logic       pix_valid = 1'b0;
  logic       pix_ready;
  logic [7:0] win0, win1, win2, win3, win4, win5, win6, win7, win_c;
  logic [2:0] win_row;
  logic [2:0] win_col;
  logic       win_valid;
  logic       win_ready = 1'b1;
  logic       frame_done;

  always #5 clk = ~clk;

  sobel_window_gen #(.IMG_W(W), .IMG_H(H)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .pix_in     (pix_in),
    .pix_sof    (pix_sof),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .win0       (win0),
    .win1       (win1),
    .win2       (win2),
    .win3       (win3),
    .win4       (win4),
    .win5       (win5),
    .win6       (win6),
    .win7       (win7),
    .win_c      (win_c),
    .win_row    (win_row),
    .win_col    (win_col),
    .win_valid  (win_valid),
    .win_ready  (win_ready),
    .frame_done (frame_done)
  );

  // w packs TL,TC,TR,ML,MR,BL,BC,BR,C with TL in the top byte
  typedef struct packed {
    logic [7:0]  r;
    logic [7:0]  c;
    logic [71:0] w;
  } win_t;

  win_t tab [NWIN];
  win_t got_q [$];
  win_t exp_q [$];

  int n_cmp = 0;
  int n_bad = 0;
  int fd_cnt = 0;
  int hold = 0;
  bit stall_arm = 1'b0;
  bit prev_xfer = 1'b0;
  win_t prev_w = '0;
  win_t snap = '0;

  function automatic logic [7:0] px(input int r, input int c);
    return 8'(r * 16 + c);
  endfunction

  function automatic win_t mk(input int r, input int c);
    win_t v;
    v.r = 8'(r);
    v.c = 8'(c);
    v.w = {px(r-1, c-1), px(r-1, c), px(r-1, c+1), px(r, c-1), px(r, c+1),
           px(r+1, c-1), px(r+1, c), px(r+1, c+1), px(r, c)};
    return v;
  endfunction

  function automatic win_t cur_win();
    win_t v;
    v.r = {5'b0, win_row};
    v.c = {5'b0, win_col};
    v.w = {win0, win1, win2, win3, win4, win5, win6, win7, win_c};
    return v;
  endfunction

  task automatic chk(input string nm, input logic [87:0] act, input logic [87:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Monitor: applies the win_ready stall, records window transfers and checks frame_done timing.
  initial begin
    win_t cw;
    bit xfer;
    forever begin
      @(negedge clk);
      cw = cur_win();
      if (hold > 0) begin
        chk("stall_hold", cw, snap);
        chk("stall_pix_ready", pix_ready, 0);
        chk("stall_win_valid", win_valid, 1);
        hold--;
        if (hold == 0) win_ready = 1'b1;
      end else if (stall_arm && win_valid && win_row == 3'd2 && win_col == 3'd3) begin
        win_ready = 1'b0;
        snap = cw;
        hold = 3;
        stall_arm = 1'b0;
      end
      if (frame_done || (prev_xfer && prev_w.r == 8'd4 && prev_w.c == 8'd6))
        chk("frame_done", frame_done, prev_xfer && prev_w.r == 8'd4 && prev_w.c == 8'd6);
      if (frame_done) fd_cnt++;
      xfer = win_valid && win_ready;
      if (xfer) got_q.push_back(cw);
      prev_xfer = xfer;
      prev_w = cw;
    end
  end

  task automatic send_pix(input logic [7:0] d, input logic sof);
    int n = 0;
    logic rdy;
    pix_in = d;
    pix_sof = sof;
    pix_valid = 1'b1;
    do begin
      @(negedge clk);
      #2;
      rdy = pix_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 200);
    if (!rdy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL pix_accept_timeout: got ready=0 after %0d cycles, expected acceptance", n);
    end
  endtask

  task automatic send_frame(input int npix, input int gap, input logic [7:0] pat);
    for (int i = 0; i < npix; i++) begin
      send_pix(px(i / W, i % W) ^ pat, i == 0);
      if (gap > 0) begin
        pix_valid = 1'b0;
        pix_sof = 1'b0;
        repeat (gap) begin
          @(posedge clk);
          #1;
        end
      end
    end
    pix_valid = 1'b0;
    pix_sof = 1'b0;
  endtask

  task automatic drain();
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic clear();
    got_q.delete();
    exp_q.delete();
    fd_cnt = 0;
  endtask

  task automatic check_windows(input string tag);
    int n;
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_win%0d", tag, i), got_q[i], exp_q[i]);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_win_valid"}, win_valid, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_pix_ready"}, pix_ready, 1);
    chk({tag, "_window"}, cur_win(), '0);
  endtask

  initial begin
    int bad_border;
    tab[0].r = 8'd1;
    tab[0].c = 8'd1;
    tab[0].w = 72'h00_01_02_10_12_20_21_22_11;
    for (int k = 1; k < NWIN; k++) tab[k] = mk(1 + k / (W - 2), 1 + k % (W - 2));

    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check_reset("post_reset");

    // full frame, no backpressure
    clear();
    send_frame(W * H, 0, 8'h00);
    drain();
    foreach (tab[k]) exp_q.push_back(tab[k]);
    check_windows("full");
    chk("full_frame_done_cnt", fd_cnt, 1);

    // win_ready held low for 3 cycles at window (2,3)
    clear();
    stall_arm = 1'b1;
    send_frame(W * H, 0, 8'h00);
    drain();
    foreach (tab[k]) exp_q.push_back(tab[k]);
    check_windows("stall");
    chk("stall_seen", stall_arm, 0);
    chk("stall_frame_done_cnt", fd_cnt, 1);

    // pixel valid one cycle in three
    clear();
    send_frame(W * H, 2, 8'h00);
    drain();
    foreach (tab[k]) exp_q.push_back(tab[k]);
    check_windows("gaps");
    chk("gaps_frame_done_cnt", fd_cnt, 1);

    // reset partway through row 3, then a clean frame
    clear();
    send_frame(3 * W + 4, 0, 8'hc5);
    drain();
    chk("prereset_count", got_q.size(), 8);
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset("midreset");
    rstn = 1'b1;
    @(posedge clk);
    #1;
    clear();
    send_frame(W * H, 0, 8'h00);
    drain();
    foreach (tab[k]) exp_q.push_back(tab[k]);
    check_windows("after_reset");
    chk("after_reset_frame_done_cnt", fd_cnt, 1);

    // sof arrives on the pixel that would have been (3,4)
    clear();
    send_frame(3 * W + 4, 0, 8'h00);
    send_frame(W * H, 0, 8'h00);
    drain();
    for (int k = 0; k < 8; k++) exp_q.push_back(tab[k]);
    foreach (tab[k]) exp_q.push_back(tab[k]);
    check_windows("resync");
    chk("resync_frame_done_cnt", fd_cnt, 1);

    // two frames back to back
    clear();
    send_frame(W * H, 0, 8'h00);
    send_frame(W * H, 0, 8'h00);
    drain();
    foreach (tab[k]) exp_q.push_back(tab[k]);
    foreach (tab[k]) exp_q.push_back(tab[k]);
    check_windows("b2b");
    chk("b2b_frame_done_cnt", fd_cnt, 2);
    bad_border = 0;
    foreach (got_q[i]) if (got_q[i].r == 8'd0 || got_q[i].c == 8'd7) bad_border++;
    chk("b2b_border_windows", bad_border, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
